// File: rtl/dff_stim_checker_pkg.sv
// Shared encodings for the flop stimulus/checker: FSM states, pattern modes, LFSR taps and seed.
package dff_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_LFSR   = 1'b1;

   // Left-shift Fibonacci form: taps 16,14,13,11 are bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/dff_stim_checker_if.sv
// Link between the checker and the flop under test: stimulus out, q/q_bar back.
interface dff_chk_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] d_out;
   logic [WIDTH-1:0] q_in;
   logic [WIDTH-1:0] q_bar_in;

   modport master (output d_out, input q_in, input q_bar_in);
   modport slave  (input d_out, output q_in, output q_bar_in);
endinterface

// File: rtl/dff_stim_checker_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load of the seed and a step enable.
// Load wins over enable; the low OUT_W bits are presented as the pattern.
module dff_chk_lfsr
   import dff_chk_pkg::*;
#(
   parameter logic [15:0] SEED  = DEFAULT_SEED,
   parameter int          OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   output logic [OUT_W-1:0] pat_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (en_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign pat_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/dff_stim_checker.sv
// Stimulus source and response checker for single-flop DUTs; counts q/q_bar mismatches per run.
// Optional first-mismatch capture enabled by DFF_STIM_CHECKER_FIRST_ERR_EN.
module dff_stim_checker
   import dff_chk_pkg::*;
#(
   parameter int          WIDTH   = 1,
   parameter int          LEN     = 256,
   parameter int          LATENCY = 1,
   parameter int          CNT_W   = 16,
   parameter logic [15:0] SEED    = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   dff_chk_if.master        dut,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
   ,
   output logic [15:0]      first_err_idx,
   output logic             first_err_vld
`endif
);

   localparam int CMAX = (LEN > LATENCY) ? LEN : LATENCY;
   localparam int CW   = $clog2(CMAX + 1);

   state_e           state_q;
   logic             mode_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] d_out_q;
   logic [WIDTH-1:0] pat;
   logic [WIDTH-1:0] lfsr_pat;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [CNT_W-1:0] err_q;
   logic [CNT_W-1:0] err_d;
   logic [LATENCY:0] dl_vld_q;
   logic [WIDTH-1:0] dl_exp_q [LATENCY+1];
   logic             start_acc;
   logic             push;
   logic             mis;

   assign start_acc = (state_q == IDLE) && start;
   assign push      = (state_q == RUN);

   dff_chk_lfsr #(
      .SEED  (SEED),
      .OUT_W (WIDTH)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load_i (start_acc),
      .en_i   (push),
      .pat_o  (lfsr_pat)
   );

   // Toggle pattern alternates starting from all-zeros on the first RUN cycle.
   always_comb begin
      pat = {WIDTH{cnt_q[0]}};
      if (mode_q == MODE_LFSR) begin
         pat = lfsr_pat;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_TOGGLE;
         cnt_q   <= '0;
         d_out_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  mode_q  <= mode;
                  cnt_q   <= '0;
                  d_out_q <= '0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               d_out_q <= pat;
               if (cnt_q == CW'(LEN - 1)) begin
                  cnt_q   <= '0;
                  state_q <= DRAIN;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (cnt_q == CW'(LATENCY - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // The final compare lands on this edge, so judge on the next count.
               done_q  <= 1'b1;
               pass_q  <= (err_d == '0);
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The tail stage lines up with the DUT output LATENCY flops after d_out changed.
   assign mis = dl_vld_q[LATENCY] &&
                ((dut.q_in != dl_exp_q[LATENCY]) || (dut.q_bar_in != ~dl_exp_q[LATENCY]));

   always_comb begin
      err_d = err_q;
      if (start_acc) begin
         err_d = '0;
      end else if (mis && (err_q != {CNT_W{1'b1}})) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_vld_q <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            dl_exp_q[i] <= '0;
         end
         err_q <= '0;
      end else begin
         dl_vld_q    <= {dl_vld_q[LATENCY-1:0], push};
         dl_exp_q[0] <= pat;
         for (int i = 1; i <= LATENCY; i++) begin
            dl_exp_q[i] <= dl_exp_q[i-1];
         end
         err_q <= err_d;
      end
   end

`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
   logic [15:0] cmp_idx_q;
   logic [15:0] fe_idx_q;
   logic        fe_vld_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmp_idx_q <= '0;
         fe_idx_q  <= '0;
         fe_vld_q  <= 1'b0;
      end else if (start_acc) begin
         cmp_idx_q <= '0;
         fe_idx_q  <= '0;
         fe_vld_q  <= 1'b0;
      end else if (dl_vld_q[LATENCY]) begin
         cmp_idx_q <= cmp_idx_q + 1'b1;
         if (mis && !fe_vld_q) begin
            fe_vld_q <= 1'b1;
            fe_idx_q <= cmp_idx_q;
         end
      end
   end

   assign first_err_idx = fe_idx_q;
   assign first_err_vld = fe_vld_q;
`endif

   assign dut.d_out = d_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_dff_stim_checker.sv
// Directed bench: four checker configurations, each wired to a behavioural flop model with selectable faults.
module tb_dff_stim_checker;
   import dff_chk_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A: 1-bit, LEN=8, LATENCY=1 -- ideal / q stuck-0 / q_bar miswired
   logic        start_a, mode_a, busy_a, done_a, pass_a;
   logic [15:0] err_a;
   int          fault_a;
   logic        qa_r;
   dff_chk_if #(.WIDTH(1)) ifa ();
   always @(posedge clk) qa_r <= ifa.d_out;
   assign ifa.q_in     = (fault_a == 1) ? 1'b0 : qa_r;
   assign ifa.q_bar_in = (fault_a == 2) ? qa_r : ~qa_r;

   // B: 4-bit, LEN=256, LFSR, ideal
   logic        start_b, mode_b, busy_b, done_b, pass_b;
   logic [15:0] err_b;
   logic [3:0]  qb_r;
   dff_chk_if #(.WIDTH(4)) ifb ();
   always @(posedge clk) qb_r <= ifb.d_out;
   assign ifb.q_in     = qb_r;
   assign ifb.q_bar_in = ~qb_r;

   // C: 1-bit, LEN=16, CNT_W=2, q stuck-0
   logic        start_c, mode_c, busy_c, done_c, pass_c;
   logic [1:0]  err_c;
   logic        qc_r;
   dff_chk_if #(.WIDTH(1)) ifc ();
   always @(posedge clk) qc_r <= ifc.d_out;
   assign ifc.q_in     = 1'b0;
   assign ifc.q_bar_in = ~qc_r;

   // D: 8-bit, LEN=1, LATENCY=3, optional q stuck-high
   logic        start_d, mode_d, busy_d, done_d, pass_d;
   logic [15:0] err_d;
   logic        fault_d;
   logic [7:0]  qd_r [3];
   dff_chk_if #(.WIDTH(8)) ifd ();
   always @(posedge clk) begin
      qd_r[0] <= ifd.d_out;
      qd_r[1] <= qd_r[0];
      qd_r[2] <= qd_r[1];
   end
   assign ifd.q_in     = fault_d ? 8'hFF : qd_r[2];
   assign ifd.q_bar_in = ~qd_r[2];

`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
   logic [15:0] fei_a, fei_b, fei_c, fei_d;
   logic        fev_a, fev_b, fev_c, fev_d;
`endif

   dff_stim_checker #(.WIDTH(1), .LEN(8), .LATENCY(1), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .dut(ifa),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a)
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      , .first_err_idx(fei_a), .first_err_vld(fev_a)
`endif
   );

   dff_stim_checker #(.WIDTH(4), .LEN(256), .LATENCY(1), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .dut(ifb),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      , .first_err_idx(fei_b), .first_err_vld(fev_b)
`endif
   );

   dff_stim_checker #(.WIDTH(1), .LEN(16), .LATENCY(1), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .dut(ifc),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c)
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      , .first_err_idx(fei_c), .first_err_vld(fev_c)
`endif
   );

   dff_stim_checker #(.WIDTH(8), .LEN(1), .LATENCY(3), .CNT_W(16)) u_d (
      .clk(clk), .rst(rst), .start(start_d), .mode(mode_d), .dut(ifd),
      .busy(busy_d), .done(done_d), .pass(pass_d), .err_cnt(err_d)
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      , .first_err_idx(fei_d), .first_err_vld(fev_d)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Start a toggle run on A; report the cycle of the first done pulse (cycle 0 = start high),
   // the number of done pulses in a 40-cycle window, and d_out in cycles 2..9.
   task automatic run_a(input int f, output int done_cyc, output int n_done, output logic [7:0] dvec);
      fault_a  = f;
      done_cyc = -1;
      n_done   = 0;
      dvec     = '0;
      @(negedge clk);
      mode_a  = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c >= 2 && c <= 9) dvec[c-2] = ifa.d_out;
         if (done_a) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
         end
         @(negedge clk);
      end
   endtask

   int          dc, nd;
   logic [7:0]  dv;
   logic [15:0] lv;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      start_a = 0; start_b = 0; start_c = 0; start_d = 0;
      mode_a  = 0; mode_b  = 1; mode_c  = 0; mode_d  = 0;
      fault_a = 0; fault_d = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",  {31'd0, busy_a}, 0);
      check("rst_done",  {31'd0, done_a}, 0);
      check("rst_pass",  {31'd0, pass_a}, 0);
      check("rst_err",   {16'd0, err_a}, 0);
      check("rst_dout",  {31'd0, ifa.d_out}, 0);
      check("rst_dout_b", {28'd0, ifb.d_out}, 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: ideal, toggle
      run_a(0, dc, nd, dv);
      check("t1_done_cyc", dc, 11);
      check("t1_done_cnt", nd, 1);
      check("t1_dout_seq", {24'd0, dv}, 32'h0000_00AA);
      check("t1_err",  {16'd0, err_a}, 0);
      check("t1_pass", {31'd0, pass_a}, 1);
      check("t1_busy", {31'd0, busy_a}, 0);
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      check("t1_fe_vld", {31'd0, fev_a}, 0);
`endif

      // 3: q stuck at 0 -> odd indices mismatch
      run_a(1, dc, nd, dv);
      check("t3_done_cyc", dc, 11);
      check("t3_err",  {16'd0, err_a}, 4);
      check("t3_pass", {31'd0, pass_a}, 0);
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      check("t3_fe_idx", {16'd0, fei_a}, 1);
      check("t3_fe_vld", {31'd0, fev_a}, 1);
`endif

      // 4: q_bar wired to q -> every compare mismatches
      run_a(2, dc, nd, dv);
      check("t4_err",  {16'd0, err_a}, 8);
      check("t4_pass", {31'd0, pass_a}, 0);
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      check("t4_fe_idx", {16'd0, fei_a}, 0);
`endif

      // 5: reset mid-run discards the run
      fault_a = 2;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_pre_busy", {31'd0, busy_a}, 1);
      check("t5_pre_err_nz", {31'd0, (err_a != 16'd0)}, 1);
      rst = 1'b0;
      @(negedge clk);
      check("t5_busy", {31'd0, busy_a}, 0);
      check("t5_err",  {16'd0, err_a}, 0);
      check("t5_dout", {31'd0, ifa.d_out}, 0);
      rst = 1'b1;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         if (done_a) nd++;
         @(negedge clk);
      end
      check("t5_no_done", nd, 0);
      run_a(0, dc, nd, dv);
      check("t5_rerun_done", dc, 11);
      check("t5_rerun_err",  {16'd0, err_a}, 0);
      check("t5_rerun_pass", {31'd0, pass_a}, 1);

      // 2: LFSR on 4 bits, LEN=256
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      dc = -1;
      lv = '0;
      for (int c = 1; c <= 300; c++) begin
         if (c >= 2 && c <= 5) lv[(c-2)*4 +: 4] = ifb.d_out;
         if (done_b && dc < 0) dc = c;
         @(negedge clk);
      end
      check("t2_lfsr_seq", {16'd0, lv}, 32'h0000_F731);
      check("t2_done_cyc", dc, 259);
      check("t2_err",  {16'd0, err_b}, 0);
      check("t2_pass", {31'd0, pass_b}, 1);

      // 6: start held every cycle of a LEN=16 run, 2-bit counter saturates
      @(negedge clk);
      start_c = 1'b1;
      @(negedge clk);
      dc = -1;
      nd = 0;
      for (int c = 1; c <= 60; c++) begin
         if (done_c) begin
            nd++;
            if (dc < 0) dc = c;
            start_c = 1'b0;
         end
         @(negedge clk);
      end
      start_c = 1'b0;
      check("t6_done_cnt", nd, 1);
      check("t6_done_cyc", dc, 19);
      check("t6_err_sat",  {30'd0, err_c}, 3);
      check("t6_pass",     {31'd0, pass_c}, 0);
`ifdef DFF_STIM_CHECKER_FIRST_ERR_EN
      check("t6_fe_idx", {16'd0, fei_c}, 1);
`endif

      // LEN=1 with LATENCY=3: ideal then q stuck high
      for (int r = 0; r < 2; r++) begin
         fault_d = (r == 1);
         @(negedge clk);
         start_d = 1'b1;
         @(negedge clk);
         start_d = 1'b0;
         dc = -1;
         nd = 0;
         for (int c = 1; c <= 20; c++) begin
            if (done_d) begin
               nd++;
               if (dc < 0) dc = c;
            end
            @(negedge clk);
         end
         check($sformatf("len1_done_cyc_%0d", r), dc, 6);
         check($sformatf("len1_done_cnt_%0d", r), nd, 1);
         check($sformatf("len1_err_%0d", r),  {16'd0, err_d}, (r == 1) ? 1 : 0);
         check($sformatf("len1_pass_%0d", r), {31'd0, pass_d}, (r == 1) ? 0 : 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
